video_scanout: RTL
==================

VIDEO_SCANOUT -- requirements
Module: video_scanout

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  H_RES 800 active pixels per line; V_RES 600 active lines
  H_FP 40, H_SYNC 128, H_BP 88 horizontal porches and sync, in pixels
  V_FP 1, V_SYNC 4, V_BP 23 vertical porches and sync, in lines
  H_POL 1, V_POL 1 sync active level
  FB_W 320, FB_H 240 framebuffer size, in source pixels
  SCALE_LOG2 1 pixel replication 2^SCALE_LOG2 in x and y (0..2)
  X0 80, Y0 60 top-left corner of the image window, in screen pixels
  ADDR_W 17 framebuffer address width; DATA_W 8 framebuffer data width
  RD_LAT 2 framebuffer read latency, cycles (1..4)
  BORDER_RGB 24'h000000 colour outside the window
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  i_pix_clk   in   1   pixel clock; sole clock
  i_rst       in   1   reset
  i_mode      in   2   colour mode: 0 grey, 1 RGB332, 2 bars, 3 blank
  i_fb_data   in   DATA_W   framebuffer read data, RD_LAT cycles after address
  o_fb_addr   out  ADDR_W   framebuffer read address
  o_fb_en     out  1   read enable
  o_hs, o_vs  out  1   syncs at the configured polarity
  o_de        out  1   data enable
  o_frame     out  1   one-cycle frame-start pulse
  o_red, o_green, o_blue  out  8   pixel colour
REQ-003 SHALL use one clock, i_pix_clk, with a synchronous, active-high reset, i_rst.

Function
REQ-004 SHALL keep internal counters h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1, where H_TOTAL = H_RES+H_FP+H_SYNC+H_BP and V_TOTAL likewise; h wraps to 0 and increments v; v wraps to 0 after (H_TOTAL-1, V_TOTAL-1).
REQ-005 SHALL define stage-0 de as h<H_RES and v<V_RES.
REQ-006 SHALL assert stage-0 hs for H_RES+H_FP <= h < H_RES+H_FP+H_SYNC, at level H_POL.
REQ-007 SHALL assert stage-0 vs by the same rule on v, at level V_POL, for the whole line.
REQ-008 SHALL assert stage-0 frame only at h=0, v=0.
REQ-009 SHALL define the window as X0 <= h < X0+FB_W*2^S and Y0 <= v < Y0+FB_H*2^S, where S = SCALE_LOG2.
REQ-010 SHALL, inside the window and in de, drive o_fb_en=1 and o_fb_addr = ((v-Y0)>>S)*FB_W + ((h-X0)>>S), registered one cycle after stage 0 (stage 1).
REQ-011 SHALL compute the address incrementally with a row-base register: no multiplier; the base advances by FB_W once every 2^S window lines.
REQ-012 SHALL, outside the window or outside de, drive o_fb_en=0 and hold o_fb_addr at its last value.
REQ-013 SHALL register colour at stage PIPE = RD_LAT+2, using the in-window flag delayed to match the data.
REQ-014 SHALL produce colour per mode:
  grey: R=G=B=data[7:0]
  RGB332: R={d[7:5],d[7:5],d[7:6]}, G={d[4:2],d[4:2],d[4:3]}, B={d[1:0]×4}
  bars: R=G=B={h[7:5],5'b0}, ignoring data
  blank: 0
REQ-015 SHALL output BORDER_RGB outside the window but inside de, and 0 when de=0.
REQ-016 SHALL delay hs, vs, de and frame by exactly PIPE cycles so they stay aligned with colour.
REQ-017 SHALL sample i_mode only on the stage-0 frame cycle; a mid-frame change takes effect from the next frame.

Reset
REQ-018 SHALL, while i_rst=1, set h=v=0, o_de=0, o_frame=0, o_fb_en=0, o_fb_addr=0, colour 0, o_hs=~H_POL, o_vs=~V_POL, flush all pipeline stages to these inactive values, and set the mode register to 0.
REQ-019 SHALL, on the first cycle after reset release, start at h=0, v=0, and pulse o_frame PIPE cycles later; a mid-frame reset restarts the frame the same way.

Structure
REQ-020 SHALL place the mode encodings and the H_TOTAL/V_TOTAL helper functions in shared package video_pkg.
REQ-021 SHALL implement the counters and stage-0 sync/de/frame in sub-module video_timing_gen.
REQ-022 SHALL implement the address and colour pipeline in video_scanout.

Verification
Common parameters: H_RES=8, V_RES=4, H_FP=1, H_SYNC=2, H_BP=1, V_FP=1, V_SYNC=1, V_BP=1, FB_W=4, FB_H=2, S=1, X0=Y0=0, RD_LAT=2.
REQ-023 SHALL verify timing: release reset -> o_frame pulses every 84 cycles, first pulse at cycle 4; o_hs high 2 cycles per 12-cycle line; o_vs high 12 cycles per frame.
REQ-024 SHALL verify addressing: o_fb_en for pixel (x=5, y=3) -> o_fb_addr=6; 8 enables per active line; addresses 0,0,1,1,2,2,3,3 on lines 0 and 1.
REQ-025 SHALL verify the data path: memory model returns data=address, mode 0 -> pixel (5,3) colour 0x060606, aligned with o_de.
REQ-026 SHALL verify the border: X0=2, S=0 -> pixels x=0,1,6,7 = BORDER_RGB with o_fb_en=0; x=2 reads address 0.
REQ-027 SHALL verify mode timing: i_mode 0->1 at mid-frame -> colour unchanged until the next o_frame; after it, data 0xE0 -> 0xFF0000.
REQ-028 SHALL verify mid-frame reset: assert i_rst at v=2 -> outputs inactive next cycle; after release, o_frame at cycle 4 and the address sequence restarts at 0.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared colour modes, pipeline record and raster size helpers
package video_pkg;

    typedef enum logic [1:0] {
        MODE_GREY   = 2'd0,
        MODE_RGB332 = 2'd1,
        MODE_BARS   = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_e;

    // Per-pixel control record carried down the scanout pipeline.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       frame;
        logic       win;
        logic [2:0] bar;
    } pipe_t;

    function automatic int h_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

    function automatic int v_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

    // One spare code so end-of-sync compares never overflow the counter width.
    function automatic int ctr_width(input int total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster counters and stage-0 sync, data-enable and frame strobes
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_RES  = 800,
    parameter int H_FP   = 40,
    parameter int H_SYNC = 128,
    parameter int H_BP   = 88,
    parameter int V_RES  = 600,
    parameter int V_FP   = 1,
    parameter int V_SYNC = 4,
    parameter int V_BP   = 23,
    parameter bit H_POL  = 1'b1,
    parameter bit V_POL  = 1'b1,
    parameter int H_W    = ctr_width(h_total(H_RES, H_FP, H_SYNC, H_BP)),
    parameter int V_W    = ctr_width(v_total(V_RES, V_FP, V_SYNC, V_BP))
) (
    input  logic           clk,
    input  logic           rst,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output logic           de,
    output logic           hs,
    output logic           vs,
    output logic           frame,
    output logic           eol,
    output logic           eof
);

    localparam int H_TOTAL = h_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_RES, V_FP, V_SYNC, V_BP);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_RES);
    localparam logic [H_W-1:0] H_SS   = H_W'(H_RES + H_FP);
    localparam logic [H_W-1:0] H_SE   = H_W'(H_RES + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_RES);
    localparam logic [V_W-1:0] V_SS   = V_W'(V_RES + V_FP);
    localparam logic [V_W-1:0] V_SE   = V_W'(V_RES + V_FP + V_SYNC);

    // Pixel counter wraps each line and steps the line counter, which wraps each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + V_W'(1);
        end else begin
            h <= h + H_W'(1);
        end
    end

    // Stage-0 strobes decoded straight from the counters.
    always_comb begin
        de    = (h < H_ACT) && (v < V_ACT);
        hs    = ((h >= H_SS) && (h < H_SE)) ? H_POL : ~H_POL;
        vs    = ((v >= V_SS) && (v < V_SE)) ? V_POL : ~V_POL;
        frame = (h == '0) && (v == '0);
        eol   = (h == H_LAST);
        eof   = (h == H_LAST) && (v == V_LAST);
    end

endmodule

// File: rtl/video_scanout.sv
// rtl/video_scanout.sv - framebuffer scanout with pixel replication, colour modes and aligned syncs
module video_scanout
    import video_pkg::*;
#(
    parameter int          H_RES      = 800,
    parameter int          V_RES      = 600,
    parameter int          H_FP       = 40,
    parameter int          H_SYNC     = 128,
    parameter int          H_BP       = 88,
    parameter int          V_FP       = 1,
    parameter int          V_SYNC     = 4,
    parameter int          V_BP       = 23,
    parameter bit          H_POL      = 1'b1,
    parameter bit          V_POL      = 1'b1,
    parameter int          FB_W       = 320,
    parameter int          FB_H       = 240,
    parameter int          SCALE_LOG2 = 1,
    parameter int          X0         = 80,
    parameter int          Y0         = 60,
    parameter int          ADDR_W     = 17,
    parameter int          DATA_W     = 8,
    parameter int          RD_LAT     = 2,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic              i_pix_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_fb_data,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic              o_fb_en,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_de,
    output logic              o_frame,
    output logic [7:0]        o_red,
    output logic [7:0]        o_green,
    output logic [7:0]        o_blue
);

    localparam int H_W  = ctr_width(h_total(H_RES, H_FP, H_SYNC, H_BP));
    localparam int V_W  = ctr_width(v_total(V_RES, V_FP, V_SYNC, V_BP));
    localparam int PIPE = RD_LAT + 2;

    localparam logic [31:0]       X0_U     = 32'(X0);
    localparam logic [31:0]       Y0_U     = 32'(Y0);
    localparam logic [31:0]       X_END_U  = 32'(X0 + (FB_W << SCALE_LOG2));
    localparam logic [31:0]       Y_END_U  = 32'(Y0 + (FB_H << SCALE_LOG2));
    localparam logic [1:0]        SUB_LAST = 2'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
    localparam pipe_t PIPE_IDLE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0, frame: 1'b0,
                                    win: 1'b0, bar: 3'b0};

    logic [H_W-1:0]    t_h;
    logic [V_W-1:0]    t_v;
    logic              s0_de, s0_hs, s0_vs, s0_frame, s0_eol, s0_eof;
    logic              h_in, v_in, s0_win;
    logic [ADDR_W-1:0] s0_addr;
    logic [ADDR_W-1:0] row_base;
    logic [1:0]        y_sub;
    mode_e             mode_q;
    pipe_t             s0;
    pipe_t             pipe [PIPE];
    pipe_t             col_in;
    logic [7:0]        px;
    logic [23:0]       rgb_q;

    video_timing_gen #(
        .H_RES (H_RES), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_RES (V_RES), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .H_POL (H_POL), .V_POL (V_POL), .H_W (H_W), .V_W (V_W)
    ) u_timing (
        .clk   (i_pix_clk),
        .rst   (i_rst),
        .h     (t_h),
        .v     (t_v),
        .de    (s0_de),
        .hs    (s0_hs),
        .vs    (s0_vs),
        .frame (s0_frame),
        .eol   (s0_eol),
        .eof   (s0_eof)
    );

    // Window test and read address: row base plus the replicated column index.
    always_comb begin
        h_in    = (32'(t_h) >= X0_U) && (32'(t_h) < X_END_U);
        v_in    = (32'(t_v) >= Y0_U) && (32'(t_v) < Y_END_U);
        s0_win  = s0_de && h_in && v_in;
        s0_addr = row_base + ADDR_W'((32'(t_h) - X0_U) >> SCALE_LOG2);
        s0      = '{hs: s0_hs, vs: s0_vs, de: s0_de, frame: s0_frame, win: s0_win,
                    bar: 3'(32'(t_h) >> 5)};
    end

    // Row base steps by one framebuffer row after every 2^S window lines; cleared each frame.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst || s0_eof) begin
            row_base <= '0;
            y_sub    <= '0;
        end else if (s0_eol && v_in) begin
            if (y_sub == SUB_LAST) begin
                y_sub    <= '0;
                row_base <= row_base + ROW_STEP;
            end else begin
                y_sub <= y_sub + 2'd1;
            end
        end
    end

    // Colour mode is latched only at frame start so a frame never mixes modes.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            mode_q <= MODE_GREY;
        end else if (s0_frame) begin
            mode_q <= mode_e'(i_mode);
        end
    end

    // Stage 1: issue the read; the address holds while no read is issued.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            o_fb_en   <= 1'b0;
            o_fb_addr <= '0;
        end else begin
            o_fb_en <= s0_win;
            if (s0_win) begin
                o_fb_addr <= s0_addr;
            end
        end
    end

    // Control delay line; slot RD_LAT meets the read data, the last slot meets the colour.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            for (int k = 0; k < PIPE; k++) begin
                pipe[k] <= PIPE_IDLE;
            end
        end else begin
            pipe[0] <= s0;
            for (int k = 1; k < PIPE; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign col_in = pipe[RD_LAT];
    assign px     = 8'(i_fb_data);

    // Colour stage: blanking, border, then per-mode expansion of the returned pixel.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst || !col_in.de) begin
            rgb_q <= '0;
        end else if (!col_in.win) begin
            rgb_q <= BORDER_RGB;
        end else begin
            case (mode_q)
                MODE_GREY:   rgb_q <= {px, px, px};
                MODE_RGB332: rgb_q <= {px[7:5], px[7:5], px[7:6],
                                       px[4:2], px[4:2], px[4:3], {4{px[1:0]}}};
                MODE_BARS:   rgb_q <= {3{col_in.bar, 5'b0}};
                default:     rgb_q <= '0;
            endcase
        end
    end

    assign o_hs    = pipe[PIPE-1].hs;
    assign o_vs    = pipe[PIPE-1].vs;
    assign o_de    = pipe[PIPE-1].de;
    assign o_frame = pipe[PIPE-1].frame;
    assign o_red   = rgb_q[23:16];
    assign o_green = rgb_q[15:8];
    assign o_blue  = rgb_q[7:0];

endmodule
